// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution for the Falco execute stage: evaluates the compare, forms targets,
// checks them against the front-end prediction and produces the redirect; 1- or 2-stage valid/ready pipe.
module branch_resolve_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic                  is_jal_i,
  input  logic                  is_jalr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] imm_i,
  input  logic                  pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] pred_target_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  taken_o,
  output logic [ADDR_WIDTH-1:0] target_o,
  output logic [ADDR_WIDTH-1:0] link_o,
  output logic                  mispredict_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic                  illegal_o,
  output logic                  misalign_o,
  output logic [CNT_WIDTH-1:0]  branch_cnt_o,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } op_e;

  // Compare outcome plus everything the prediction check still needs.
  typedef struct packed {
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] link;
    logic                  illegal;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
  } stage1_t;

  typedef struct packed {
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] link;
    logic                  mispredict;
    logic [ADDR_WIDTH-1:0] redirect;
    logic                  illegal;
    logic                  misalign;
  } result_t;

  function automatic result_t resolve_outcome(input stage1_t s);
    result_t r;
    r.taken      = s.taken;
    r.target     = s.target;
    r.link       = s.link;
    r.illegal    = s.illegal;
    r.mispredict = (s.taken != s.pred_taken) || (s.taken && (s.target != s.pred_target));
    r.redirect   = s.taken ? s.target : s.link;
    r.misalign   = s.taken && s.target[1];
    return r;
  endfunction

  stage1_t               req_s1;
  logic                  cond_taken;
  logic                  cond_illegal;
  logic [ADDR_WIDTH-1:0] jalr_sum;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (op_i)
      OP_BEQ:  cond_taken = (a_i == b_i);
      OP_BNE:  cond_taken = (a_i != b_i);
      OP_BLT:  cond_taken = ($signed(a_i) <  $signed(b_i));
      OP_BGE:  cond_taken = ($signed(a_i) >= $signed(b_i));
      OP_BLTU: cond_taken = (a_i <  b_i);
      OP_BGEU: cond_taken = (a_i >= b_i);
      default: cond_illegal = 1'b1;
    endcase

    jalr_sum           = ADDR_WIDTH'(a_i) + imm_i;
    req_s1             = '0;
    req_s1.link        = pc_i + ADDR_WIDTH'(4);
    req_s1.pred_taken  = pred_taken_i;
    req_s1.pred_target = pred_target_i;
    if (is_jalr_i) begin
      req_s1.taken  = 1'b1;
      req_s1.target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
    end else if (is_jal_i) begin
      req_s1.taken  = 1'b1;
      req_s1.target = pc_i + imm_i;
    end else begin
      req_s1.taken   = cond_taken;
      req_s1.illegal = cond_illegal;
      req_s1.target  = pc_i + imm_i;
    end
  end

  // ready_o stays low until the first edge after reset release.
  logic rdy_en_q;
  logic rdy_en_d;
  assign rdy_en_d = 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_en_q <= 1'b0;
    else         rdy_en_q <= rdy_en_d;
  end

  logic    s1_valid;
  logic    s1_advance;
  logic    accept;
  logic    retire;
  logic    out_valid;
  result_t out_res;

  assign ready_o = rdy_en_q && (!s1_valid || s1_advance);
  assign accept  = valid_i && ready_o && !flush_i;
  assign retire  = out_valid && ready_i && !flush_i;

  if (PIPE_STAGES == 1) begin : g_one
    logic    s1_valid_q, s1_valid_d;
    result_t s1_res_q,   s1_res_d;

    assign s1_advance = !s1_valid_q || ready_i;

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_res_d   = s1_res_q;
      if (flush_i) begin
        s1_valid_d = 1'b0;
      end else if (s1_advance) begin
        s1_valid_d = accept;
        if (accept) s1_res_d = resolve_outcome(req_s1);
      end
    end

    // NOTE: payload flops are reset as well so every output reads 0 out of reset, not just valid_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_valid_q <= 1'b0;
        s1_res_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_res_q   <= s1_res_d;
      end
    end

    assign s1_valid  = s1_valid_q;
    assign out_valid = s1_valid_q;
    assign out_res   = s1_res_q;
  end else begin : g_two
    logic    s1_valid_q, s1_valid_d;
    stage1_t s1_req_q,   s1_req_d;
    logic    s2_valid_q, s2_valid_d;
    result_t s2_res_q,   s2_res_d;
    logic    s2_advance;

    assign s2_advance = !s2_valid_q || ready_i;
    assign s1_advance = !s1_valid_q || s2_advance;

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_req_d   = s1_req_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      if (flush_i) begin
        s1_valid_d = 1'b0;
        s2_valid_d = 1'b0;
      end else begin
        if (s1_advance) begin
          s1_valid_d = accept;
          if (accept) s1_req_d = req_s1;
        end
        if (s2_advance) begin
          s2_valid_d = s1_valid_q;
          if (s1_valid_q) s2_res_d = resolve_outcome(s1_req_q);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_valid_q <= 1'b0;
        s1_req_q   <= '0;
        s2_valid_q <= 1'b0;
        s2_res_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_req_q   <= s1_req_d;
        s2_valid_q <= s2_valid_d;
        s2_res_q   <= s2_res_d;
      end
    end

    assign s1_valid  = s1_valid_q;
    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
  end

  logic [CNT_WIDTH-1:0] branch_cnt_q,     branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (retire) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      if (out_res.mispredict && (mispredict_cnt_q != '1))
        mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign valid_o          = out_valid;
  assign taken_o          = out_res.taken;
  assign target_o         = out_res.target;
  assign link_o           = out_res.link;
  assign mispredict_o     = out_res.mispredict;
  assign redirect_pc_o    = out_res.redirect;
  assign illegal_o        = out_res.illegal;
  assign misalign_o       = out_res.misalign;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: 1-stage, 2-stage and 2-bit-counter instances, scored against
// a behavioural model of branch resolution with per-instance expected-result queues.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic [2:0]  op;
    logic        jal;
    logic        jalr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
  } req_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        mispredict;
    logic [31:0] redirect;
    logic        illegal;
    logic        misalign;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  op = '0;
  logic        jal = 1'b0, jalr = 1'b0, pt = 1'b0, flush = 1'b0;
  logic [31:0] a = '0, b = '0, pc = '0, imm = '0, ptgt = '0;
  logic        valid1 = 1'b0, ready1 = 1'b1, valid2 = 1'b0, ready2 = 1'b1;

  logic        ready_o1, valid_o1, taken1, misp1, ill1, mis1;
  logic [31:0] target1, link1, redir1, bcnt1, mcnt1;
  logic        ready_o2, valid_o2, taken2, misp2, ill2, mis2;
  logic [31:0] target2, link2, redir2, bcnt2, mcnt2;
  logic        ready_os, valid_os, takens, misps, ills, miss;
  logic [31:0] targets, links, redirs;
  logic [1:0]  bcnts, mcnts;

  exp_t out1, out2, outs;
  assign out1 = {taken1, target1, link1, misp1, redir1, ill1, mis1};
  assign out2 = {taken2, target2, link2, misp2, redir2, ill2, mis2};
  assign outs = {takens, targets, links, misps, redirs, ills, miss};

  branch_resolve_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PIPE_STAGES(1), .CNT_WIDTH(32)) u_p1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid1), .ready_o(ready_o1), .op_i(op),
    .is_jal_i(jal), .is_jalr_i(jalr), .a_i(a), .b_i(b), .pc_i(pc), .imm_i(imm),
    .pred_taken_i(pt), .pred_target_i(ptgt), .flush_i(flush), .valid_o(valid_o1),
    .ready_i(ready1), .taken_o(taken1), .target_o(target1), .link_o(link1),
    .mispredict_o(misp1), .redirect_pc_o(redir1), .illegal_o(ill1), .misalign_o(mis1),
    .branch_cnt_o(bcnt1), .mispredict_cnt_o(mcnt1));

  branch_resolve_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PIPE_STAGES(2), .CNT_WIDTH(32)) u_p2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid2), .ready_o(ready_o2), .op_i(op),
    .is_jal_i(jal), .is_jalr_i(jalr), .a_i(a), .b_i(b), .pc_i(pc), .imm_i(imm),
    .pred_taken_i(pt), .pred_target_i(ptgt), .flush_i(flush), .valid_o(valid_o2),
    .ready_i(ready2), .taken_o(taken2), .target_o(target2), .link_o(link2),
    .mispredict_o(misp2), .redirect_pc_o(redir2), .illegal_o(ill2), .misalign_o(mis2),
    .branch_cnt_o(bcnt2), .mispredict_cnt_o(mcnt2));

  branch_resolve_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PIPE_STAGES(1), .CNT_WIDTH(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid1), .ready_o(ready_os), .op_i(op),
    .is_jal_i(jal), .is_jalr_i(jalr), .a_i(a), .b_i(b), .pc_i(pc), .imm_i(imm),
    .pred_taken_i(pt), .pred_target_i(ptgt), .flush_i(flush), .valid_o(valid_os),
    .ready_i(ready1), .taken_o(takens), .target_o(targets), .link_o(links),
    .mispredict_o(misps), .redirect_pc_o(redirs), .illegal_o(ills), .misalign_o(miss),
    .branch_cnt_o(bcnts), .mispredict_cnt_o(mcnts));

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[3][$];
  int   retires[3];
  int   misps_seen[3];
  logic hold_pend[3];
  exp_t hold_val[3];
  logic last_acc[3];
  req_t cur_req;

  // Branch semantics from first principles: signed compares via int, wrap via 32-bit arithmetic.
  function automatic exp_t model(input req_t r);
    exp_t        e;
    logic        cond;
    logic        ill;
    logic [31:0] tgt;
    cond = 1'b0;
    ill  = 1'b0;
    case (r.op)
      3'd0: cond = (r.a == r.b);
      3'd1: cond = (r.a != r.b);
      3'd4: cond = (int'(r.a) <  int'(r.b));
      3'd5: cond = (int'(r.a) >= int'(r.b));
      3'd6: cond = (r.a <  r.b);
      3'd7: cond = (r.a >= r.b);
      default: ill = 1'b1;
    endcase
    tgt = r.pc + r.imm;
    if (r.jalr) begin
      cond = 1'b1;
      ill  = 1'b0;
      tgt  = (r.a + r.imm) & 32'hFFFF_FFFE;
    end else if (r.jal) begin
      cond = 1'b1;
      ill  = 1'b0;
    end
    e.taken      = cond;
    e.target     = tgt;
    e.link       = r.pc + 32'd4;
    e.illegal    = ill;
    e.redirect   = cond ? tgt : e.link;
    e.mispredict = cond ? (!r.pt || (r.ptgt != tgt)) : r.pt;
    e.misalign   = cond && tgt[1];
    return e;
  endfunction

  function automatic req_t rand_req();
    req_t       r;
    exp_t       e;
    logic [11:0] im12;
    r.op   = 3'($urandom_range(0, 7));
    r.jal  = ($urandom_range(0, 7) == 0);
    r.jalr = ($urandom_range(0, 7) == 0);
    r.a    = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)) - 32'd2;
    case ($urandom_range(0, 2))
      0:       r.b = r.a;
      1:       r.b = $urandom;
      default: r.b = 32'($urandom_range(0, 3)) - 32'd2;
    endcase
    r.pc   = $urandom & 32'hFFFF_FFFC;
    im12   = 12'($urandom);
    r.imm  = {{20{im12[11]}}, im12};
    r.pt   = 1'($urandom_range(0, 1));
    r.ptgt = '0;
    e      = model(r);
    r.ptgt = $urandom_range(0, 1) ? e.target : $urandom;
    return r;
  endfunction

  task automatic drive(input req_t r);
    cur_req = r;
    op = r.op; jal = r.jal; jalr = r.jalr; a = r.a; b = r.b;
    pc = r.pc; imm = r.imm; pt = r.pt; ptgt = r.ptgt;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      retires[i]    = 0;
      misps_seen[i] = 0;
      hold_pend[i]  = 1'b0;
      last_acc[i]   = 1'b0;
    end
  endtask

  // Scoreboard step for one instance, evaluated just before the active edge.
  task automatic score(input int idx, input logic vin, input logic rin, input logic rout,
                       input logic vout, input exp_t outv);
    exp_t e;
    if (hold_pend[idx]) begin
      vectors++;
      if (vout !== 1'b1 || outv !== hold_val[idx]) begin
        miscompares++;
        $display("FAIL hold[%0d]: got valid=%b %h, required valid=1 %h", idx, vout, outv, hold_val[idx]);
      end
    end
    hold_pend[idx] = vout && !rin && !flush;
    hold_val[idx]  = outv;
    if (vout && rin && !flush) begin
      vectors++;
      if (q[idx].size() == 0) begin
        miscompares++;
        $display("FAIL retire[%0d]: got unexpected result %h, required none", idx, outv);
      end else begin
        e = q[idx].pop_front();
        if (outv !== e) begin
          miscompares++;
          $display("FAIL result[%0d]: got %h, required %h", idx, outv, e);
        end
        retires[idx]++;
        if (e.mispredict) misps_seen[idx]++;
      end
    end
    last_acc[idx] = vin && rout && !flush;
    if (last_acc[idx]) q[idx].push_back(model(cur_req));
  endtask

  task automatic check_cnts();
    logic [1:0] sb, sm;
    sb = (retires[2] > 3) ? 2'd3 : 2'(retires[2]);
    sm = (misps_seen[2] > 3) ? 2'd3 : 2'(misps_seen[2]);
    vectors += 3;
    if ({bcnt1, mcnt1} !== {32'(retires[0]), 32'(misps_seen[0])}) begin
      miscompares++;
      $display("FAIL cnt_p1: got %0d/%0d, required %0d/%0d", bcnt1, mcnt1, retires[0], misps_seen[0]);
    end
    if ({bcnt2, mcnt2} !== {32'(retires[1]), 32'(misps_seen[1])}) begin
      miscompares++;
      $display("FAIL cnt_p2: got %0d/%0d, required %0d/%0d", bcnt2, mcnt2, retires[1], misps_seen[1]);
    end
    if ({bcnts, mcnts} !== {sb, sm}) begin
      miscompares++;
      $display("FAIL cnt_sat: got %0d/%0d, required %0d/%0d", bcnts, mcnts, sb, sm);
    end
  endtask

  // Inputs are driven at the falling edge; one call advances exactly one clock.
  task automatic cycle();
    #1;
    score(0, valid1, ready1, ready_o1, valid_o1, out1);
    score(1, valid2, ready2, ready_o2, valid_o2, out2);
    score(2, valid1, ready1, ready_os, valid_os, outs);
    @(posedge clk);
    if (flush) for (int i = 0; i < 3; i++) q[i].delete();
    @(negedge clk);
    check_cnts();
  endtask

  task automatic apply_reset();
    valid1 = 1'b0; valid2 = 1'b0; flush = 1'b0; ready1 = 1'b1; ready2 = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready_o1, valid_o1, out1, bcnt1, mcnt1, ready_o2, valid_o2, out2, bcnt2, mcnt2,
         ready_os, valid_os, outs, bcnts, mcnts} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got p1 %b%b %h p2 %b%b %h, required all zero",
               ready_o1, valid_o1, out1, ready_o2, valid_o2, out2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    #1;
    vectors++;
    if ({ready_o1, ready_o2, ready_os} !== 3'b000) begin
      miscompares++;
      $display("FAIL ready_at_release: got %b, required 000", {ready_o1, ready_o2, ready_os});
    end
    @(negedge clk);
    vectors++;
    if ({ready_o1, ready_o2, ready_os} !== 3'b111) begin
      miscompares++;
      $display("FAIL ready_after_edge: got %b, required 111", {ready_o1, ready_o2, ready_os});
    end
  endtask

  task automatic test_signed_unsigned();
    req_t r;
    apply_reset();
    r = '0; r.op = 3'b100; r.a = 32'hFFFF_FFFF; r.b = 32'd1; r.pc = 32'h40; r.imm = 32'h10;
    drive(r); valid1 = 1'b1;
    cycle();
    valid1 = 1'b0;
    vectors++;
    if ({last_acc[0], valid_o1, taken1} !== 3'b111) begin
      miscompares++;
      $display("FAIL blt_signed: got acc/valid/taken=%b, required 111", {last_acc[0], valid_o1, taken1});
    end
    cycle();
    r.op = 3'b110;
    drive(r); valid1 = 1'b1;
    cycle();
    valid1 = 1'b0;
    vectors++;
    if ({last_acc[0], valid_o1, taken1} !== 3'b110) begin
      miscompares++;
      $display("FAIL bltu_unsigned: got acc/valid/taken=%b, required 110", {last_acc[0], valid_o1, taken1});
    end
    cycle();
  endtask

  task automatic test_mispredict();
    req_t r;
    apply_reset();
    r = '0; r.op = 3'b000; r.a = 32'd5; r.b = 32'd5; r.pc = 32'h100; r.imm = 32'h20;
    drive(r); valid1 = 1'b1;
    cycle();
    valid1 = 1'b0;
    vectors++;
    if ({valid_o1, taken1, target1, misp1, redir1, mcnt1} !== {1'b1, 1'b1, 32'h120, 1'b1, 32'h120, 32'd0}) begin
      miscompares++;
      $display("FAIL beq_redirect: got v%b t%b tgt %h m%b rd %h cnt %0d, required v1 t1 tgt 120 m1 rd 120 cnt 0",
               valid_o1, taken1, target1, misp1, redir1, mcnt1);
    end
    cycle();
    vectors++;
    if (mcnt1 !== 32'd1) begin
      miscompares++;
      $display("FAIL mispredict_cnt: got %0d, required 1", mcnt1);
    end
  endtask

  task automatic test_jalr();
    req_t r;
    r = '0; r.jalr = 1'b1; r.jal = 1'b1; r.op = 3'b010; r.a = 32'h2003; r.imm = 32'h4;
    r.pc = 32'h300; r.pt = 1'b1; r.ptgt = 32'h2006;
    drive(r); valid1 = 1'b1;
    cycle();
    valid1 = 1'b0;
    vectors++;
    if ({taken1, target1, misp1, link1, mis1, ill1} !== {1'b1, 32'h2006, 1'b0, 32'h304, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL jalr: got t%b tgt %h m%b link %h mis%b ill%b, required t1 tgt 2006 m0 link 304 mis1 ill0",
               taken1, target1, misp1, link1, mis1, ill1);
    end
    cycle();
  endtask

  task automatic test_reserved();
    req_t r;
    r = '0; r.op = 3'b010; r.a = 32'd7; r.b = 32'd7; r.pc = 32'h500; r.imm = 32'h8; r.pt = 1'b1;
    r.ptgt = 32'h508;
    drive(r); valid1 = 1'b1;
    cycle();
    valid1 = 1'b0;
    vectors++;
    if ({ill1, taken1, misp1} !== 3'b101) begin
      miscompares++;
      $display("FAIL reserved_op: got ill/taken/misp=%b, required 101", {ill1, taken1, misp1});
    end
    cycle();
  endtask

  task automatic test_backpressure();
    req_t rs[3];
    int   k;
    apply_reset();
    for (int i = 0; i < 3; i++) rs[i] = rand_req();
    k = 0;
    ready2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(rs[k < 3 ? k : 2]); valid2 = (k < 3);
      cycle();
      if (last_acc[1]) k++;
    end
    #1;
    vectors++;
    if ({k, ready_o2, valid_o2} !== {32'd2, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL backpressure_fill: got accepts=%0d ready=%b valid=%b, required 2 0 1", k, ready_o2, valid_o2);
    end
    @(negedge clk);
    check_cnts();
    ready2 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(rs[k < 3 ? k : 2]); valid2 = (k < 3);
      cycle();
      if (last_acc[1]) k++;
    end
    valid2 = 1'b0;
    vectors++;
    if ({k, bcnt2, 32'(q[1].size())} !== {32'd3, 32'd3, 32'd0}) begin
      miscompares++;
      $display("FAIL backpressure_drain: got accepts=%0d cnt=%0d pending=%0d, required 3 3 0", k, bcnt2, q[1].size());
    end
  endtask

  task automatic test_flush();
    apply_reset();
    ready2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(rand_req()); valid2 = 1'b1;
      cycle();
    end
    drive(rand_req()); valid2 = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; valid2 = 1'b0;
    #1;
    vectors++;
    if ({valid_o2, ready_o2, bcnt2, mcnt2} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL flush: got valid=%b ready=%b cnt=%0d/%0d, required 0 1 0/0", valid_o2, ready_o2, bcnt2, mcnt2);
    end
    @(negedge clk);
    check_cnts();
    ready2 = 1'b1;
    repeat (3) cycle();
    vectors++;
    if ({valid_o2, bcnt2} !== {1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL flush_drop: got valid=%b cnt=%0d, required 0 0", valid_o2, bcnt2);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(rand_req()); valid1 = 1'b1;
      cycle();
    end
    valid1 = 1'b0;
    repeat (2) cycle();
    vectors++;
    if ({bcnts, bcnt1} !== {2'd3, 32'd5}) begin
      miscompares++;
      $display("FAIL saturation: got sat=%0d wide=%0d, required 3 5", bcnts, bcnt1);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      drive(rand_req());
      valid1 = ($urandom_range(0, 9) < 7);
      valid2 = ($urandom_range(0, 9) < 7);
      ready1 = ($urandom_range(0, 3) != 0);
      ready2 = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 29) == 0);
      cycle();
    end
    valid1 = 1'b0; valid2 = 1'b0; flush = 1'b0; ready1 = 1'b1; ready2 = 1'b1;
    repeat (4) cycle();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (q[i].size() != 0) begin
        miscompares++;
        $display("FAIL random_drain[%0d]: got %0d results outstanding, required 0", i, q[i].size());
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    ready1 = 1'b0; ready2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(rand_req()); valid1 = 1'b1; valid2 = 1'b1;
      cycle();
    end
    valid1 = 1'b0; valid2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready_o1, valid_o1, out1, bcnt1, mcnt1, ready_o2, valid_o2, out2, bcnt2, mcnt2,
         ready_os, valid_os, outs, bcnts, mcnts} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got p1 v%b %h p2 v%b %h, required all zero", valid_o1, out1, valid_o2, out2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    ready1 = 1'b1; ready2 = 1'b1;
    repeat (3) cycle();
    vectors++;
    if ({valid_o1, valid_o2, bcnt1, bcnt2} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_discard: got valid %b%b cnt %0d/%0d, required 00 0/0", valid_o1, valid_o2, bcnt1, bcnt2);
    end
  endtask

  initial begin
    reset_model();
    cur_req = '0;
    test_reset();
    test_signed_unsigned();
    test_mispredict();
    test_jalr();
    test_reserved();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Pipelined branch/jump resolution unit for the Falco execute stage. It evaluates conditional-branch compares, computes branch and jump targets, and checks the outcome against the front-end prediction. It emits a redirect on mispredict. Width and pipeline depth are parametrised, flow uses a valid/ready handshake, and the block keeps saturating performance counters.

Parameters:
DATA_WIDTH, 32, operand width (rs1/rs2)
ADDR_WIDTH, 32, PC/target width
PIPE_STAGES, 1, latency in cycles; legal values 1 or 2
CNT_WIDTH, 32, width of each saturating performance counter

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  input request valid
ready_o  out  1  unit can accept a request this cycle
op_i  in  3  compare op: 000 BEQ, 001 BNE, 010/011 reserved, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
is_jal_i  in  1  unconditional PC-relative jump
is_jalr_i  in  1  unconditional register-indirect jump
a_i  in  DATA_WIDTH  rs1 value
b_i  in  DATA_WIDTH  rs2 value
pc_i  in  ADDR_WIDTH  instruction PC
imm_i  in  ADDR_WIDTH  sign-extended offset
pred_taken_i  in  1  front-end predicted taken
pred_target_i  in  ADDR_WIDTH  front-end predicted target
flush_i  in  1  kill all in-flight requests
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
taken_o  out  1  resolved taken
target_o  out  ADDR_WIDTH  resolved taken-target
link_o  out  ADDR_WIDTH  pc_i+4 (rd writeback for JAL/JALR)
mispredict_o  out  1  outcome differs from prediction
redirect_pc_o  out  ADDR_WIDTH  correct next PC
illegal_o  out  1  reserved op on a conditional branch
misalign_o  out  1  taken target with bit[1] set
branch_cnt_o  out  CNT_WIDTH  resolved, non-flushed requests
mispredict_cnt_o  out  CNT_WIDTH  resolved mispredicts

Behaviour:
- Reset (async assert, sync deassert): all stage valids 0, every output 0, counters 0. ready_o=1 one cycle after deassert.
- Accept: a request transfers on valid_i && ready_o. A result retires on valid_o && ready_i.
- Each stage register advances when it is empty or the next stage/downstream is consuming. ready_o = !s1_valid || s1_advance. Full throughput is 1 request/cycle. There is no combinational path from valid_i to valid_o.
- Latency: result appears exactly PIPE_STAGES cycles after acceptance when ready_i is held 1.
- PIPE_STAGES=1: all logic below registers once. PIPE_STAGES=2: stage 1 registers the compare result, target and link; stage 2 registers the mispredict/redirect logic.
- Compare: BLT/BGE compare signed; BLTU/BGEU compare unsigned. Reserved op gives taken=0 and illegal_o=1.
- Jumps: is_jal_i or is_jalr_i forces taken=1 and ignores op_i. illegal_o=0. If both are set, is_jalr_i wins.
- Targets: branch/JAL target = pc_i+imm_i; JALR target = (a_i[ADDR_WIDTH-1:0]+imm_i) with bit0 cleared. Additions wrap modulo 2^ADDR_WIDTH. link_o = pc_i+4, also wrapping.
- mispredict_o = (taken != pred_taken_i) || (taken && target != pred_target_i). pred_target_i is ignored when not taken.
- redirect_pc_o = taken ? target : link.
- misalign_o = taken && target[1]. It is reported only; it does not change mispredict_o.
- All result outputs hold stable while valid_o && !ready_i (backpressure). ready_o drops once the pipe is full.
- flush_i: at the next edge, clears all stage valids. A request presented in the same cycle as flush_i is dropped. Counters do not count flushed requests. flush_i has priority over retire in the same cycle.
- Counters: increment at retire only. mispredict_cnt increments when the retiring result has mispredict_o=1. Both counters saturate at all-ones.
- Reset mid-operation discards all in-flight requests immediately.

Test Plan:
- Signed/unsigned compare, PIPE_STAGES=1: BLT a=0xFFFFFFFF, b=1 -> taken_o=1; BLTU with the same operands -> taken_o=0. Each result appears 1 cycle after accept.
- Mispredict redirect: BEQ a=b=5, pc=0x100, imm=0x20, pred_taken=0 -> taken=1, target=0x120, mispredict=1, redirect=0x120, mispredict_cnt 0->1.
- JALR: a=0x2003, imm=0x4, pred_taken=1, pred_target=0x2006 -> target=0x2006, mispredict=0, link=pc+4, misalign=1.
- Backpressure, PIPE_STAGES=2: 3 back-to-back requests with ready_i=0 for 4 cycles -> ready_o falls after 2 accepts, outputs hold stable. After ready_i=1, all 3 retire in order and branch_cnt=3.
- Flush: 2 requests in flight plus flush_i=1 with valid_i=1 -> valid_o=0 next cycle, counters unchanged, ready_o=1.
- Reserved op 010 -> illegal_o=1, taken=0. Counter saturation with CNT_WIDTH=2: 5 retires -> branch_cnt_o=3. Async reset mid-stream -> all outputs 0 immediately.
